wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DEPTH, default 4: long-latency holding-FIFO entries (power of two, 2..16).
REQ-002 Parameter STARVE_LIMIT, default 8: consecutive lost cycles before forced drain (1..255).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 PipeValid  in  1  pipeline writeback wants the register-file write port this cycle.
REQ-006 PipeReg  in  5  pipeline destination register.
REQ-007 PipeData  in  64  pipeline write data (already MemToReg-selected).
REQ-008 LongValid  in  1  long-latency unit (divider/miss return) offers a result.
REQ-009 LongReg  in  5  long-latency destination register.
REQ-010 LongData  in  64  long-latency result.
REQ-011 LongReady  out  1  FIFO accepts; transfer when LongValid&LongReady.
REQ-012 RegWrite  out  1  registered register-file write enable.
REQ-013 Reg2Write  out  5  registered write address.
REQ-014 Data2Write  out  64  registered write data.
REQ-015 PipeStall  out  1  registered; pipeline holds writeback next cycle.
REQ-016 PendingMask  out  32  bit r set while any FIFO entry targets r.
REQ-017 ProtoErr  out  1  sticky; PipeValid seen while PipeStall high.

Function
REQ-018 Pipe path latency exactly 1 cycle: granted PipeValid at edge N drives RegWrite/Reg2Write/Data2Write after edge N.
REQ-019 Long path: accepted entry enters FIFO; earliest write is the cycle after acceptance (no same-cycle bypass).
REQ-020 LongReady = FIFO not full, from current occupancy only (no credit for same-cycle pop).
REQ-021 Push and pop in one cycle are both honoured; occupancy unchanged.
REQ-022 FSM states IDLE (FIFO empty), DRAIN (non-empty, pipe priority), FORCE (FIFO head priority).
REQ-023 IDLE->DRAIN on push; DRAIN->IDLE when last entry pops with no push.
REQ-024 In DRAIN, PipeValid wins the port; otherwise FIFO head pops and writes.
REQ-025 Starve counter increments each DRAIN cycle the head loses, clears on any pop or IDLE entry; at STARVE_LIMIT, DRAIN->FORCE.
REQ-026 On FORCE entry PipeStall=1; in FORCE FIFO head writes every cycle, PipeValid ignored and sets ProtoErr.
REQ-027 FORCE->IDLE when FIFO empties, else FORCE->DRAIN after one pop; PipeStall deasserts on leaving FORCE.
REQ-028 No port contender: RegWrite=0, Reg2Write/Data2Write hold last values.
REQ-029 PendingMask updated same edge as push/pop; entries to the same register counted, bit clears only when none remain.
REQ-030 FIFO preserves order; pointers wrap modulo DEPTH.

Reset
REQ-031 rst_n low, asynchronously: state IDLE, FIFO empty, counter 0, RegWrite=0, Reg2Write=0, Data2Write=0, PipeStall=0, PendingMask=0, ProtoErr=0, LongReady=1 after release.
REQ-032 Reset mid-FORCE or with FIFO occupied discards all entries; no write issued.

Configuration
REQ-033 WB_ZERO_REG_SUPPRESS_EN defined: any grant with register 31 yields RegWrite=0 (still consumes grant/pops entry) and never sets PendingMask[31].
REQ-034 Undefined: register 31 treated as any other register.

Structure
REQ-035 Shared package: 64-bit data width, 5-bit register index, ZERO_REG=31, FSM state enum.
REQ-036 One sub-module wb_hold_fifo (DEPTH entries, push/pop, full/empty, occupancy).

Verification
REQ-037 PipeValid, PipeReg=5, PipeData=0xAA, FIFO empty -> next cycle RegWrite=1, Reg2Write=5, Data2Write=0xAA.
REQ-038 LongValid Reg=7 Data=0x11 with PipeValid idle -> PendingMask[7]=1, write Reg 7 0x11 one cycle later, mask clears.
REQ-039 DEPTH=4, five back-to-back LongValid, PipeValid held high -> LongReady=0 after 4 accepts, fifth stalled, no drops.
REQ-040 STARVE_LIMIT=8, one entry queued, PipeValid high 8 cycles -> PipeStall=1, head writes, PipeValid during stall sets ProtoErr.
REQ-041 rst_n pulsed low mid-FORCE with 3 entries -> all outputs reset values immediately, no later writes.
REQ-042 Macro defined, PipeReg=31 -> RegWrite stays 0; undefined -> RegWrite=1, Reg2Write=31.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned REG_W  = 5;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

endpackage

// File: rtl/wb_hold_fifo.sv
// Holding FIFO for long-latency results; also reports which registers are pending.
module wb_hold_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [REG_W-1:0]         push_reg,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [REG_W-1:0]         head_reg,
  output logic [DATA_W-1:0]        head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              pending
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         cnt;
  logic [DEPTH-1:0]    vld;
  logic [REG_W-1:0]    regs  [DEPTH];
  logic [DATA_W-1:0]   datas [DEPTH];
  logic                push_ok, pop_ok;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign head_reg  = regs[rd_ptr];
  assign head_data = datas[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      vld    <= '0;
    end else begin
      if (push_ok) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      regs[wr_ptr]  <= push_reg;
      datas[wr_ptr] <= push_data;
    end
  end

  // Mask derived from live slots, so duplicates keep a bit set until the last one pops.
  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld[i]) pending[regs[i]] = 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and long-latency results.
// Optional: define WB_ZERO_REG_SUPPRESS_EN to drop all writes to register 31.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PipeValid,
  input  logic [4:0]        PipeReg,
  input  logic [63:0]       PipeData,
  input  logic              LongValid,
  input  logic [4:0]        LongReg,
  input  logic [63:0]       LongData,
  output logic              LongReady,
  output logic              RegWrite,
  output logic [4:0]        Reg2Write,
  output logic [63:0]       Data2Write,
  output logic              PipeStall,
  output logic [31:0]       PendingMask,
  output logic              ProtoErr
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_t            state, state_nx;
  logic [7:0]        starve, starve_nx;
  logic              push, pop, pipe_grant, grant, wr_en;
  logic [REG_W-1:0]  head_reg, wr_reg;
  logic [DATA_W-1:0] head_data, wr_data;
  logic              full, empty;
  logic [CW-1:0]     count;
  logic [31:0]       pending;
  logic              last_out;

  wb_hold_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_reg  (LongReg),
    .push_data (LongData),
    .pop       (pop),
    .head_reg  (head_reg),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .pending   (pending)
  );

  assign LongReady = !full;
  assign push      = LongValid && !full;
  assign last_out  = (count == CW'(1)) && !push;

`ifdef WB_ZERO_REG_SUPPRESS_EN
  assign PendingMask = pending & ~(32'd1 << ZERO_REG);
  assign wr_en       = grant && (wr_reg != ZERO_REG);
`else
  assign PendingMask = pending;
  assign wr_en       = grant;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      starve <= '0;
    end else begin
      state  <= state_nx;
      starve <= starve_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    starve_nx = starve;
    case (state)
      ST_IDLE: begin
        starve_nx = '0;
        if (push) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (PipeValid) begin
          starve_nx = starve + 8'd1;
          if (starve_nx == 8'(STARVE_LIMIT)) state_nx = ST_FORCE;
        end else begin
          starve_nx = '0;
          if (last_out) state_nx = ST_IDLE;
        end
      end
      ST_FORCE: begin
        starve_nx = '0;
        state_nx  = last_out ? ST_IDLE : ST_DRAIN;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    pipe_grant = 1'b0;
    pop        = 1'b0;
    case (state)
      ST_IDLE:  pipe_grant = PipeValid;
      ST_DRAIN: begin
        pipe_grant = PipeValid;
        pop        = !PipeValid && !empty;
      end
      ST_FORCE: pop = !empty;
      default: ;
    endcase
    grant   = pipe_grant || pop;
    wr_reg  = pipe_grant ? PipeReg  : head_reg;
    wr_data = pipe_grant ? PipeData : head_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite   <= 1'b0;
      Reg2Write  <= '0;
      Data2Write <= '0;
      PipeStall  <= 1'b0;
      ProtoErr   <= 1'b0;
    end else begin
      RegWrite <= wr_en;
      if (grant) begin
        Reg2Write  <= wr_reg;
        Data2Write <= wr_data;
      end
      PipeStall <= (state_nx == ST_FORCE);
      ProtoErr  <= ProtoErr || (PipeStall && PipeValid);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed vector bench for wb_port_arbiter (default parameters).
module tb_wb_port_arbiter;

`ifdef WB_ZERO_REG_SUPPRESS_EN
  localparam bit SUP = 1'b1;
`else
  localparam bit SUP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PipeValid, LongValid;
  logic [4:0]  PipeReg, LongReg;
  logic [63:0] PipeData, LongData;
  logic        LongReady, RegWrite, PipeStall, ProtoErr;
  logic [4:0]  Reg2Write;
  logic [63:0] Data2Write;
  logic [31:0] PendingMask;

  int n_checks = 0;
  int n_fail   = 0;

  wb_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .PipeValid(PipeValid), .PipeReg(PipeReg), .PipeData(PipeData),
    .LongValid(LongValid), .LongReg(LongReg), .LongData(LongData),
    .LongReady(LongReady), .RegWrite(RegWrite), .Reg2Write(Reg2Write),
    .Data2Write(Data2Write), .PipeStall(PipeStall), .PendingMask(PendingMask),
    .ProtoErr(ProtoErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [4:0]  preg;
    logic [63:0] pdata;
    logic        lv;
    logic [4:0]  lreg;
    logic [63:0] ldata;
    logic        rw;
    logic [4:0]  wreg;
    logic [63:0] wdata;
    logic [31:0] mask;
  } vec_t;

  vec_t vec [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic pv, input logic [4:0] pr, input logic [63:0] pd,
                       input logic lv, input logic [4:0] lr, input logic [63:0] ld);
    PipeValid = pv; PipeReg = pr; PipeData = pd;
    LongValid = lv; LongReg = lr; LongData = ld;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  function automatic vec_t mk(input logic pv, input logic [4:0] pr, input logic [63:0] pd,
                              input logic lv, input logic [4:0] lr, input logic [63:0] ld,
                              input logic rw, input logic [4:0] wr, input logic [63:0] wd,
                              input logic [31:0] m);
    vec_t v;
    v.pv = pv; v.preg = pr; v.pdata = pd; v.lv = lv; v.lreg = lr; v.ldata = ld;
    v.rw = rw; v.wreg = wr; v.wdata = wd; v.mask = m;
    return v;
  endfunction

  initial begin
    logic [63:0] got [$];
    int          accepted;
    bit          seen;

    vec[0]  = mk(1, 5,  64'hAA, 0, 0, 0,      1,        5,  64'hAA, 32'h0);
    vec[1]  = mk(0, 0,  0,      0, 0, 0,      0,        5,  64'hAA, 32'h0);
    vec[2]  = mk(0, 0,  0,      1, 7, 64'h11, 0,        5,  64'hAA, 32'h80);
    vec[3]  = mk(0, 0,  0,      0, 0, 0,      1,        7,  64'h11, 32'h0);
    vec[4]  = mk(0, 0,  0,      0, 0, 0,      0,        7,  64'h11, 32'h0);
    vec[5]  = mk(1, 31, 64'h31, 0, 0, 0,      !SUP,     31, 64'h31, 32'h0);
    vec[6]  = mk(1, 4,  64'h44, 1, 3, 64'h33, 1,        4,  64'h44, 32'h8);
    vec[7]  = mk(0, 0,  0,      1, 3, 64'h35, 1,        3,  64'h33, 32'h8);
    vec[8]  = mk(0, 0,  0,      0, 0, 0,      1,        3,  64'h35, 32'h0);
    vec[9]  = mk(0, 0,  0,      1, 31, 64'h99, 0,       3,  64'h35, SUP ? 32'h0 : 32'h8000_0000);
    vec[10] = mk(0, 0,  0,      0, 0, 0,      !SUP,     31, 64'h99, 32'h0);

    // Asynchronous reset takes effect without a clock edge.
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_reg", Reg2Write, 0);
    chk("rst_data", Data2Write, 0);
    chk("rst_stall", PipeStall, 0);
    chk("rst_mask", PendingMask, 0);
    chk("rst_protoerr", ProtoErr, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_longready", LongReady, 1);

    for (int i = 0; i < 11; i++) begin
      drive(vec[i].pv, vec[i].preg, vec[i].pdata, vec[i].lv, vec[i].lreg, vec[i].ldata);
      step();
      chk($sformatf("v%0d_regwrite", i), RegWrite, vec[i].rw);
      chk($sformatf("v%0d_reg", i), Reg2Write, vec[i].wreg);
      chk($sformatf("v%0d_data", i), Data2Write, vec[i].wdata);
      chk($sformatf("v%0d_mask", i), PendingMask, vec[i].mask);
      chk($sformatf("v%0d_stall", i), PipeStall, 0);
    end

    // Starvation: one queued entry loses to the pipe until the limit forces it out.
    drive(0, 0, 0, 1, 9, 64'h77);
    step();
    for (int k = 1; k <= 8; k++) begin
      drive(1, 1, 64'(k), 0, 0, 0);
      step();
      chk($sformatf("starve%0d_stall", k), PipeStall, (k == 8));
      chk($sformatf("starve%0d_data", k), Data2Write, 64'(k));
    end
    drive(1, 1, 64'hF0, 0, 0, 0);
    step();
    chk("force_regwrite", RegWrite, 1);
    chk("force_reg", Reg2Write, 9);
    chk("force_data", Data2Write, 64'h77);
    chk("force_protoerr", ProtoErr, 1);
    chk("force_stall_off", PipeStall, 0);
    chk("force_mask", PendingMask, 0);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("protoerr_sticky", ProtoErr, 1);
    do_reset();
    chk("protoerr_cleared", ProtoErr, 0);

    // Fill to capacity with the pipe holding the port; the fifth offer must wait.
    accepted = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1, 2, 64'hBEEF, 1, 5'(10 + accepted), 64'h101 + 64'(accepted));
      if (LongReady) accepted++;
      step();
    end
    chk("full_accepts", accepted, 4);
    chk("full_longready", LongReady, 0);
    chk("full_mask", PendingMask, 32'h0000_3C00);
    got.delete();
    drive(0, 0, 0, 1, 14, 64'h105);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (LongValid && LongReady) begin
        seen = 1;
        step();
        drive(0, 0, 0, 0, 0, 0);
      end else begin
        step();
      end
      if (RegWrite) got.push_back(Data2Write);
    end
    chk("fifth_accepted", seen, 1);
    chk("drain_count", got.size(), 5);
    for (int k = 0; k < 5 && k < got.size(); k++)
      chk($sformatf("drain_order%0d", k), got[k], 64'h101 + 64'(k));
    chk("drain_mask", PendingMask, 0);

    // Reset while forcing with three entries queued.
    do_reset();
    drive(0, 0, 0, 1, 20, 64'hA0);
    step();
    drive(1, 1, 64'h1, 1, 21, 64'hA1);
    step();
    drive(1, 1, 64'h2, 1, 22, 64'hA2);
    step();
    drive(1, 1, 64'h3, 0, 0, 0);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      seen = PipeStall;
    end
    chk("reached_force", seen, 1);
    chk("force_pending3", PendingMask, 32'h0070_0000);
    drive(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_regwrite", RegWrite, 0);
    chk("midrst_reg", Reg2Write, 0);
    chk("midrst_data", Data2Write, 0);
    chk("midrst_stall", PipeStall, 0);
    chk("midrst_mask", PendingMask, 0);
    chk("midrst_protoerr", ProtoErr, 0);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (RegWrite) seen = 1;
    end
    chk("postrst_no_write", seen, 0);
    chk("postrst_longready", LongReady, 1);
    chk("postrst_mask", PendingMask, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
